// File: rtl/char_pixgen.sv
// char_pixgen: text-mode pixel generator that fetches glyph rows, serialises them MSB first and keeps the syncs aligned.
// Define CHAR_PIXGEN_BLINK_EN to include the frame blink counter; otherwise blink is tied low.
module char_pixgen (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixclk,
  input  logic        ld,
  input  logic [7:0]  chr_in,
  input  logic [7:0]  att_in,
  input  logic [3:0]  row_in,
  input  logic        blank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] fnt_addr,
  input  logic [7:0]  fnt_data,
  output logic [7:0]  attcode,
  output logic        pixel,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        blink
);

  logic [7:0] att_a;
  logic [7:0] shreg;
  logic       load_pending;
  logic       blank_d;
  logic       hsync_d;
  logic       vsync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fnt_addr     <= '0;
      att_a        <= '0;
      load_pending <= 1'b0;
      shreg        <= '0;
      attcode      <= '0;
      blank_d      <= 1'b0;
      hsync_d      <= 1'b1;
      vsync_d      <= 1'b1;
      blank        <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
    end else if (pixclk) begin
      // A pending glyph wins over shifting, so a new ld discards the old glyph's remaining bits.
      if (load_pending) begin
        shreg   <= fnt_data;
        attcode <= att_a;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
      load_pending <= ld;
      if (ld) begin
        fnt_addr <= {chr_in, row_in};
        att_a    <= att_in;
      end
      blank_d <= blank_in;
      hsync_d <= hsync_in;
      vsync_d <= vsync_in;
      blank   <= blank_d;
      hsync   <= hsync_d;
      vsync   <= vsync_d;
    end
  end

  assign pixel = shreg[7];

`ifdef CHAR_PIXGEN_BLINK_EN
  logic [4:0] fcnt;

  // vsync_d holds the previous tick's sample, so it doubles as the edge detector history.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
    end else if (pixclk && vsync_d && !vsync_in) begin
      fcnt <= fcnt + 5'd1;
    end
  end

  assign blink = fcnt[4];
`else
  assign blink = 1'b0;
`endif

endmodule

// File: doc/char_pixgen.md
# char_pixgen

Text-mode pixel generator for the 9-bit-per-pixel display pipeline, directly upstream of the final pixel stage. Per character cell it takes the character code, attribute and scan-line row from the screen-memory fetch stage, reads the glyph row from the synchronous font ROM, and serialises it MSB first at one pixel per `pixclk` tick. It also delays blank/hsync/vsync so they stay aligned with the serialised pixels, and generates the frame-rate `blink` signal. All outputs are registered and feed the pixel stage unchanged.

## Interface
- No parameters.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous reset, active-high.
- `pixclk` input 1: pixel-rate clock enable, one `clk` cycle wide; at least 2 `clk` cycles between assertions.
- `ld` input 1: cell start; sampled only on `pixclk` ticks.
- `chr_in` input 8: character code; valid with `ld`.
- `att_in` input 8: attribute byte; valid with `ld`.
- `row_in` input 4: glyph scan line 0..15; valid with `ld`.
- `blank_in` input 1: display enable, 1 = visible.
- `hsync_in` input 1: horizontal sync, active-low.
- `vsync_in` input 1: vertical sync, active-low.
- `fnt_addr` output 12: font ROM address `{chr, row}`.
- `fnt_data` input 8: font ROM data; valid 1 `clk` after `fnt_addr` changes.
- `attcode` output 8: attribute for the current pixel.
- `pixel` output 1: glyph bit, 1 = foreground.
- `blank` output 1: delayed `blank_in`.
- `hsync` output 1: delayed `hsync_in`.
- `vsync` output 1: delayed `vsync_in`.
- `blink` output 1: blink phase.

## Operation
- All state advances only on `clk` edges where `pixclk`=1 ("ticks"). Exception: `rst`, which acts on any `clk` edge.
- Stage A, on a tick with `ld`=1:
  - `fnt_addr <= {chr_in, row_in}`.
  - `att_a <= att_in`.
  - Set `load_pending`.
- Stage B, on the next tick:
  - If `load_pending`: `shreg <= fnt_data`, `attcode <= att_a`, clear `load_pending`.
  - Otherwise: `shreg <= {shreg[6:0], 1'b0}`.
  - `pixel` is `shreg[7]`.
- `ld` on consecutive or closer-than-8 ticks: the new cell overrides the current one; remaining bits of the old glyph are discarded.
- No `ld` after 8 shifts: `shreg` shifts in zeros, so `pixel`=0 (background) and `attcode` holds its value.
- Timing path: `blank_in`, `hsync_in` and `vsync_in` pass through two tick-qualified register stages. This keeps them aligned with `pixel`.
- Blink counter: 5-bit `fcnt`.
  - Increments on ticks where the sampled `vsync_in` goes 1 to 0 (previous sample 1, current 0).
  - Wraps 31 to 0.
  - `blink = fcnt[4]`, so it toggles every 16 frames.

## Timing
- Reset values:
  - `fnt_addr`=0, `attcode`=0, `pixel`=0, `blank`=0, `hsync`=1, `vsync`=1, `blink`=0.
  - `shreg`=0, `fcnt`=0, `load_pending`=0.
  - Both timing delay stages reset to blank=0, hsync=1, vsync=1.
- `rst` asserted mid-cell: everything returns to reset values at that edge. The first cell after reset needs a fresh `ld`.
- Latency: inputs sampled at tick Tn (`ld`/`chr_in`/`att_in`/`row_in` and timing signals) appear on outputs right after the edge of tick Tn+1.
  - Glyph bit 7 appears at Tn+1, bit 0 at Tn+8.
- `fnt_data` is sampled at Tn+1. The minimum `pixclk` spacing of 2 `clk` guarantees the ROM has responded by then.
- `blink` updates 1 `clk` after the qualifying tick. It is not pipeline-aligned, since it only changes during vertical sync.

## Configuration
- `CHAR_PIXGEN_BLINK_EN` defined: frame counter present, behaviour as above.
- Not defined: `fcnt` and the vsync edge detector are removed and `blink` is tied to 0. All other behaviour is identical.

## Test plan
- Reset: `rst`=1 for 3 `clk` -> `pixel`=0, `blank`=0, `hsync`=1, `vsync`=1, `attcode`=0x00, `blink`=0, `fnt_addr`=0x000.
- Single cell: `ld` with `chr_in`=0x41, `row_in`=3, `att_in`=0x1E; ROM returns 0xA5 for address 0x413 -> `fnt_addr`=0x413 after Tn; `pixel` sequence 1,0,1,0,0,1,0,1 at Tn+1..Tn+8 with `attcode`=0x1E; then 0 from Tn+9.
- Back-to-back cells: `ld` every 8 ticks with glyphs 0xFF then 0x81 -> 16 pixels 1×8 then 1,0,0,0,0,0,0,1 with no gap; `attcode` switches exactly at the 9th pixel.
- Early reload: second `ld` 4 ticks after the first -> only 4 bits of the first glyph are output, then the second glyph starts at its bit 7.
- Sync alignment: `hsync_in` low for ticks 10..19 together with cells -> `hsync` low exactly for output ticks 11..20, coincident with the pixels of those cells; same for `blank`.
- Blink: 32 vsync pulses with the macro defined -> `blink` is 0 for frames 0..15 and 1 for 16..31, then 0 again. Without the macro, `blink` stays 0.
